// File: rtl/range_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : range_tracker_pkg
// Purpose  : Shared types and floating-point format constants for range_tracker
// Revision : 1.0 - initial release
// ============================================================================
package range_tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] c_NAN_HALF       = 32'h0000_7E00;
    localparam logic [31:0] c_NAN_SINGLE     = 32'h7FC0_0000;
    localparam int          c_EXP_W_HALF     = 5;
    localparam int          c_EXP_W_SINGLE   = 8;

    function automatic int exp_width(input string prec);
        return (prec == "SINGLE") ? c_EXP_W_SINGLE : c_EXP_W_HALF;
    endfunction

    function automatic logic [31:0] nan_pattern(input string prec);
        return (prec == "SINGLE") ? c_NAN_SINGLE : c_NAN_HALF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_order_compare.sv
`default_nettype none
// ============================================================================
// Module   : fp_order_compare
// Purpose  : Combinational sign-magnitude ordering of two IEEE-754 values
// Revision : 1.0 - initial release
// ============================================================================
module fp_order_compare
    import range_tracker_pkg::*;
#(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF"
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            a_lt_b,
    output logic            a_gt_b,
    output logic            a_nan
);

    localparam int EXP_W = exp_width(PRECISION);
    localparam int MAN_W = BITS - 1 - EXP_W;

    logic            w_sign_a;
    logic            w_sign_b;
    logic [BITS-2:0] w_mag_a;
    logic [BITS-2:0] w_mag_b;
    logic            w_both_zero;

    assign w_sign_a    = a[BITS-1];
    assign w_sign_b    = b[BITS-1];
    assign w_mag_a     = a[BITS-2:0];
    assign w_mag_b     = b[BITS-2:0];
    // +0 and -0 differ only in sign, so they must be caught before the sign test
    assign w_both_zero = (w_mag_a == '0) && (w_mag_b == '0);

    always_comb begin
        a_lt_b = 1'b0;
        a_gt_b = 1'b0;
        if (!w_both_zero) begin
            if (w_sign_a != w_sign_b) begin
                a_lt_b = w_sign_a;
                a_gt_b = w_sign_b;
            end else if (!w_sign_a) begin
                a_lt_b = (w_mag_a < w_mag_b);
                a_gt_b = (w_mag_a > w_mag_b);
            end else begin
                a_lt_b = (w_mag_a > w_mag_b);
                a_gt_b = (w_mag_a < w_mag_b);
            end
        end
    end

    assign a_nan = (&a[BITS-2 -: EXP_W]) && (|a[MAN_W-1:0]);

endmodule
`default_nettype wire

// File: rtl/range_tracker.sv
`default_nettype none
// ============================================================================
// Module   : range_tracker
// Purpose  : Per-block min/max/count/NaN tracker over a floating-point stream
// Revision : 1.0 - initial release
// ============================================================================
module range_tracker
    import range_tracker_pkg::*;
#(
    parameter int    BITS       = 16,
    parameter string PRECISION  = "HALF",
    parameter int    COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COUNT_BITS-1:0] block_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS-1:0]       out_min,
    output logic [BITS-1:0]       out_max,
    output logic [COUNT_BITS-1:0] out_count,
    output logic                  out_nan
);

    localparam logic [31:0]     c_NAN_FULL = nan_pattern(PRECISION);
    localparam logic [BITS-1:0] c_NAN      = c_NAN_FULL[BITS-1:0];

    state_t                r_state;
    logic [COUNT_BITS-1:0] r_len;
    logic [COUNT_BITS-1:0] r_n;
    logic [BITS-1:0]       r_min;
    logic [BITS-1:0]       r_max;
    logic [COUNT_BITS-1:0] r_count;
    logic                  r_nan;

    logic                  w_lo_lt, w_lo_gt, w_lo_nan;
    logic                  w_hi_lt, w_hi_gt, w_hi_nan;
    logic                  w_unused_cmp;
    logic [COUNT_BITS-1:0] w_len_in;
    logic [COUNT_BITS-1:0] w_n_next;

    fp_order_compare #(.BITS(BITS), .PRECISION(PRECISION)) u_cmp_min (
        .a      (in_data),
        .b      (r_min),
        .a_lt_b (w_lo_lt),
        .a_gt_b (w_lo_gt),
        .a_nan  (w_lo_nan)
    );

    fp_order_compare #(.BITS(BITS), .PRECISION(PRECISION)) u_cmp_max (
        .a      (in_data),
        .b      (r_max),
        .a_lt_b (w_hi_lt),
        .a_gt_b (w_hi_gt),
        .a_nan  (w_hi_nan)
    );

    assign w_unused_cmp = w_lo_gt ^ w_hi_lt ^ w_hi_nan;
    assign w_len_in     = (block_len == '0) ? COUNT_BITS'(1) : block_len;
    assign w_n_next     = r_n + COUNT_BITS'(1);

    assign in_ready  = (r_state != ST_HOLD);
    assign out_valid = (r_state == ST_HOLD);
    assign out_min   = r_min;
    assign out_max   = r_max;
    assign out_count = r_count;
    assign out_nan   = r_nan;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_n     <= '0;
            r_min   <= '0;
            r_max   <= '0;
            r_count <= '0;
            r_nan   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_len <= w_len_in;
                        r_n   <= COUNT_BITS'(1);
                        // An all-NaN block reports the canonical NaN as both bounds
                        if (w_lo_nan) begin
                            r_min   <= c_NAN;
                            r_max   <= c_NAN;
                            r_count <= '0;
                            r_nan   <= 1'b1;
                        end else begin
                            r_min   <= in_data;
                            r_max   <= in_data;
                            r_count <= COUNT_BITS'(1);
                            r_nan   <= 1'b0;
                        end
                        r_state <= (w_len_in == COUNT_BITS'(1)) ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_n <= w_n_next;
                        if (w_lo_nan) begin
                            r_nan <= 1'b1;
                        end else if (r_count == '0) begin
                            r_min   <= in_data;
                            r_max   <= in_data;
                            r_count <= COUNT_BITS'(1);
                        end else begin
                            if (w_lo_lt) r_min <= in_data;
                            if (w_hi_gt) r_max <= in_data;
                            r_count <= r_count + COUNT_BITS'(1);
                        end
                        if (w_n_next == r_len) r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_range_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_range_tracker
// Purpose  : Self-checking bench for range_tracker (HALF precision)
// Revision : 1.0 - initial release
// ============================================================================
module tb_range_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] block_len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_min;
    logic [15:0] out_max;
    logic [15:0] out_count;
    logic        out_nan;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] q[$];
    logic [15:0] specials[9] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
                                 16'h7C01, 16'hFFFF, 16'h0001, 16'h8001};

    range_tracker #(.BITS(16), .PRECISION("HALF"), .COUNT_BITS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .block_len (block_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_count (out_count),
        .out_nan   (out_nan)
    );

    always #5 clk = ~clk;

    // Reference model: values mapped onto a signed integer line, ±0 both land on 0
    function automatic int keyf(input logic [15:0] x);
        int m;
        m = int'(x[14:0]);
        return x[15] ? -m : m;
    endfunction

    function automatic bit is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
    endfunction

    task automatic model(output logic [15:0] mn, output logic [15:0] mx,
                         output logic [15:0] cnt, output logic nan);
        mn = 16'h7E00; mx = 16'h7E00; cnt = 0; nan = 0;
        foreach (q[i]) begin
            if (is_nan(q[i])) nan = 1;
            else begin
                if (cnt == 0) begin mn = q[i]; mx = q[i]; end
                else begin
                    if (keyf(q[i]) < keyf(mn)) mn = q[i];
                    if (keyf(q[i]) > keyf(mx)) mx = q[i];
                end
                cnt++;
            end
        end
    endtask

    function automatic logic [15:0] rnd_sample();
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 8)];
        return 16'($urandom);
    endfunction

    task automatic drive_block(input int blen, input bit gaps);
        int w;
        foreach (q[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            block_len = (i == 0) ? 16'(blen) : 16'($urandom);
            in_data   = q[i];
            in_valid  = 1'b1;
            w = 0;
            while (!in_ready && w < 20) begin @(negedge clk); w++; end
            if (w == 20) begin
                n_fail++;
                $display("FAIL drive_timeout: in_ready=%b required 1", in_ready);
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            in_data = 16'($urandom);
        end
    endtask

    task automatic recv(input int hold, output logic [15:0] mn, output logic [15:0] mx,
                        output logic [15:0] cnt, output logic nan, output int lat,
                        output logic rdy_after);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
        mn = out_min; mx = out_max; cnt = out_count; nan = out_nan;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        rdy_after = in_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 0; out_ready = 0; block_len = 0; in_data = 0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid, out_min, out_max, out_count, out_nan} !== {1'b1, 1'b0, 49'h0})
            begin n_fail++; $display("FAIL reset_state: rdy=%b vld=%b min=%h max=%h cnt=%0d nan=%b required 1 0 0 0 0 0",
                  in_ready, out_valid, out_min, out_max, out_count, out_nan); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        int          vlen[4]    = '{4, 3, 2, 2};
        logic [15:0] vs[4][4]   = '{'{16'h3C00, 16'hBC00, 16'h4000, 16'h3800},
                                    '{16'h7E00, 16'h3C00, 16'h7C00, 16'h0000},
                                    '{16'h7E00, 16'h7FFF, 16'h0000, 16'h0000},
                                    '{16'h8000, 16'h0000, 16'h0000, 16'h0000}};
        logic [15:0] emin[4]    = '{16'hBC00, 16'h3C00, 16'h7E00, 16'h8000};
        logic [15:0] emax[4]    = '{16'h4000, 16'h7C00, 16'h7E00, 16'h8000};
        logic [15:0] ecnt[4]    = '{16'd4, 16'd2, 16'd0, 16'd2};
        logic        enan[4]    = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] mn, mx, cnt;
        logic        nan, rdy;
        int          lat;
        for (int v = 0; v < 4; v++) begin
            q.delete();
            for (int i = 0; i < vlen[v]; i++) q.push_back(vs[v][i]);
            drive_block(vlen[v], 1'b0);
            recv(0, mn, mx, cnt, nan, lat, rdy);
            n_tests++;
            if ({mn, mx, cnt, nan} !== {emin[v], emax[v], ecnt[v], enan[v]}) begin
                n_fail++;
                $display("FAIL vector%0d: min=%h max=%h cnt=%0d nan=%b required %h %h %0d %b",
                         v, mn, mx, cnt, nan, emin[v], emax[v], ecnt[v], enan[v]);
            end
            n_tests++;
            if (lat !== 1) begin n_fail++; $display("FAIL vector%0d_latency: got %0d required 1", v, lat); end
        end
    endtask

    task automatic test_hold();
        logic [15:0] mn, mx, cnt;
        logic        nan, rdy;
        int          lat;
        q.delete(); q.push_back(16'h3800);
        drive_block(0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if ({out_valid, in_ready, out_min, out_max, out_count} !== {1'b1, 1'b0, 16'h3800, 16'h3800, 16'd1}) begin
                n_fail++;
                $display("FAIL hold_stable%0d: vld=%b rdy=%b min=%h max=%h cnt=%0d required 1 0 3800 3800 1",
                         k, out_valid, in_ready, out_min, out_max, out_count);
            end
        end
        recv(0, mn, mx, cnt, nan, lat, rdy);
        n_tests++;
        if ({mn, mx, nan, rdy} !== {16'h3800, 16'h3800, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL len0_result: min=%h max=%h nan=%b rdy_after=%b required 3800 3800 0 1", mn, mx, nan, rdy);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] mn, mx, cnt, emn, emx, ecnt;
        logic        nan, enan, rdy;
        int          lat;
        q.delete(); q.push_back(16'hC800); q.push_back(16'h4800);
        drive_block(4, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, out_valid, out_count, out_min} !== {1'b1, 1'b0, 16'd0, 16'h0}) begin
            n_fail++;
            $display("FAIL async_reset: rdy=%b vld=%b cnt=%0d min=%h required 1 0 0 0",
                     in_ready, out_valid, out_count, out_min);
        end
        @(negedge clk); reset = 1'b0;
        q.delete();
        q.push_back(16'h3400); q.push_back(16'h3500); q.push_back(16'h3600); q.push_back(16'h3300);
        model(emn, emx, ecnt, enan);
        drive_block(4, 1'b0);
        recv(1, mn, mx, cnt, nan, lat, rdy);
        n_tests++;
        if ({mn, mx, cnt, nan, lat == 1} !== {emn, emx, ecnt, enan, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_block: min=%h max=%h cnt=%0d nan=%b lat=%0d required %h %h %0d %b 1",
                     mn, mx, cnt, nan, lat, emn, emx, ecnt, enan);
        end
    endtask

    task automatic test_random();
        logic [15:0] mn, mx, cnt, emn, emx, ecnt;
        logic        nan, enan, rdy;
        int          lat, blen, nsamp;
        for (int b = 0; b < 40; b++) begin
            blen  = $urandom_range(0, 8);
            nsamp = (blen == 0) ? 1 : blen;
            q.delete();
            for (int i = 0; i < nsamp; i++) q.push_back(rnd_sample());
            model(emn, emx, ecnt, enan);
            drive_block(blen, 1'b1);
            recv($urandom_range(0, 3), mn, mx, cnt, nan, lat, rdy);
            n_tests++;
            if ({mn, mx, cnt, nan} !== {emn, emx, ecnt, enan}) begin
                n_fail++;
                $display("FAIL random%0d: min=%h max=%h cnt=%0d nan=%b required %h %h %0d %b",
                         b, mn, mx, cnt, nan, emn, emx, ecnt, enan);
            end
            n_tests++;
            if ({lat == 1, rdy} !== 2'b11) begin
                n_fail++;
                $display("FAIL random%0d_timing: lat=%0d rdy_after=%b required 1 1", b, lat, rdy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/range_tracker.md
# range_tracker

Streaming floating-point range tracker: accepts a valid/ready stream of half- or single-precision samples and, over each block of `block_len` samples, computes the minimum and maximum value seen. It emits them as a held result with its own valid/ready handshake. It is the producer side of our clipping path: it generates the `min`/`max` bounds that the clip stage consumes, from calibration or previous-frame data.

## Interface
- `BITS`, 16: sample width; 16 for half, 32 for single.
- `PRECISION`, "HALF": "HALF" or "SINGLE"; selects exponent/mantissa split and canonical NaN.
- `COUNT_BITS`, 16: width of block length and sample counters.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `block_len`  in  COUNT_BITS  samples per block; sampled only on the first accepted sample of a block; 0 is treated as 1.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  sample accepted when `in_valid && in_ready`.
- `in_data`  in  BITS  IEEE-754 sample.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_min`, `out_max`  out  BITS  block minimum/maximum.
- `out_count`  out  COUNT_BITS  number of non-NaN samples in the block.
- `out_nan`  out  1  at least one NaN seen in the block.

## Operation
- FSM states: IDLE, ACCUM, HOLD.
  - `in_ready = (state != HOLD)`.
  - `out_valid = (state == HOLD)`.
- IDLE, on accept:
  - latch `len = max(block_len,1)`; set sample counter `n = 1`.
  - non-NaN sample: load min = max = sample, count = 1, nan flag = 0.
  - NaN sample: set "empty", count = 0, nan flag = 1.
  - next state is HOLD if `len == 1`, else ACCUM.
- ACCUM, on accept:
  - `n++`.
  - NaN sample: sets nan flag only.
  - non-NaN sample while empty: loads min/max.
  - non-NaN sample otherwise: min = sample if sample < min; max = sample if sample > max; count++.
  - when `n` reaches `len`, go to HOLD.
- HOLD: results are stable; on `out_ready`, go to IDLE.
- All-NaN block: `out_min = out_max` = canonical quiet NaN (`16'h7E00` HALF, `32'h7FC00000` SINGLE); `out_count = 0`; `out_nan = 1`.
- Ordering:
  - total order on sign-magnitude; ±inf are ordinary extremes.
  - +0 and −0 compare equal.
  - denormals are compared exactly.
  - ties keep the incumbent, so the first-seen of ±0 is retained.
- NaN: exponent all ones and mantissa ≠ 0.
- Counters do not saturate. `len` ≤ 2^COUNT_BITS−1 by construction.

## Timing
- Reset values: state IDLE; `in_ready = 1`; `out_valid = 0`; `out_min`, `out_max`, `out_count` = 0; `out_nan = 0`.
- One sample per cycle is sustained in IDLE/ACCUM.
- `out_valid` rises the cycle after the last sample of a block is accepted.
- Results are registered; no combinational path from `in_data` to outputs.
- HOLD → IDLE on the cycle after the `out_ready` handshake, so `in_ready` returns then. There is a 1-cycle bubble per block and no bypass.
- `block_len` changes mid-block have no effect until the next block.
- Reset mid-block or in HOLD discards the partial result immediately (asynchronous).
- `in_valid` low in ACCUM: state and counters hold.

## Structure
- Package `range_tracker_pkg`:
  - state enum;
  - canonical NaN constants per precision;
  - exponent/mantissa width constants keyed on PRECISION.
- Sub-module `fp_order_compare` (BITS, PRECISION):
  - combinational; outputs `a_lt_b`, `a_gt_b`, `a_nan`;
  - zero-equality handling is done inside it.
- Two instances, one against min and one against max.

## Test plan
- HALF, block_len=4, samples 3C00, BC00, 4000, 3800 → out_min=BC00, out_max=4000, out_count=4, out_nan=0; out_valid rises 1 cycle after the 4th accept.
- block_len=3, samples 7E00, 3C00, 7C00 → min=3C00, max=7C00 (+inf), count=2, nan=1.
- block_len=2, samples 7E00, 7FFF → min=max=7E00, count=0, nan=1.
- block_len=2, samples 8000, 0000 → min=max=8000 (tie keeps first), count=2.
- block_len=0, one sample 3800 → treated as 1; result min=max=3800. Hold out_ready low for 5 cycles: outputs stable and in_ready=0. After the handshake, in_ready returns the next cycle.
- Assert reset after 2 of 4 samples, then send a fresh block of 4 → the result reflects only the new block. Random in_valid/out_ready gaps give the same results as the gap-free run.
